mua_serial_to_parallel: RTL and testbench
=========================================

// Module: mua_serial_to_parallel
// PURPOSE
//  Packs a serial per-channel MUA stream (one 32-bit sample + 12-bit channel per beat) back into
//  5-lane comb words (160-bit data, 60-bit channel vector), the inverse of the comb-to-serial path.
//  Sits between the host/replay FIFO and the comb-domain consumers (threshold/offset bank loaders,
//  spike-detect replay). It also counts complete frames.
// PARAMETERS
//  NUM_CH  160  channels per frame; must be a multiple of LANES
//  LANES   5    lanes per comb word
//  DW      32   sample width per lane
//  CW      12   channel-index width per lane
// PORTS
//  bus_clk         in   1        clock
//  xike_reset_n    in   1        synchronous reset, active-low
//  s_valid         in   1        serial beat valid
//  s_ready         out  1        serial beat ready
//  s_data          in   DW       sample
//  s_ch            in   CW       channel index of sample
//  m_comb_valid    out  1        comb word valid
//  m_comb_ready    in   1        comb word ready (e.g. !fifo_full)
//  m_comb_data     out  LANES*DW lane k = bits [k*DW +: DW]
//  m_comb_ch       out  LANES*CW lane k = bits [k*CW +: CW]
//  frame_No        out  32       completed frames since reset
//  seq_err         out  1        1-cycle pulse on channel-sequence error (MUA_CH_CHECK_EN only)
// BEHAVIOUR
//  - Reset (xike_reset_n=0 at a bus_clk edge): lane_cnt=0, accumulator cleared, m_comb_valid=0,
//    m_comb_data/m_comb_ch=0, frame_No=0, seq_err=0. A partial group at reset is discarded.
//  - Accept = s_valid & s_ready. Beat goes to lane lane_cnt; lane_cnt 0..LANES-1 wraps to 0.
//  - Lanes 0..LANES-2 are held in the accumulator. On the LANES-1 beat, accumulator + incoming beat
//    load the output register. m_comb_valid is high the next cycle, so latency is 1 cycle from the last beat.
//  - s_ready = (lane_cnt != LANES-1) | !m_comb_valid | m_comb_ready. This gives full 1 beat/cycle
//    throughput. Backpressure stalls only the group-closing beat.
//  - Output held stable while m_comb_valid & !m_comb_ready. m_comb_valid clears on handshake unless
//    a new group closes in the same cycle; in that case it stays 1 with the new data.
//  - Data bits pass unmodified (no offset add-back, bit0 not forced).
//  - frame_No increments by 1 on a closing beat with s_ch == NUM_CH-1. It wraps at 2^32-1 -> 0.
// CONFIGURATION
//  MUA_CH_CHECK_EN defined:
//  - expected_ch counter (0..NUM_CH-1, wraps) tracks the next channel.
//  - An accepted beat with s_ch != expected_ch pulses seq_err for 1 cycle and drops the partial group
//    (lane_cnt=0).
//  - If s_ch % LANES == 0, that beat starts a new group at lane 0 with expected_ch = s_ch+1.
//    Otherwise the beat is dropped and beats keep being dropped (seq_err only on the first)
//    until one with s_ch % LANES == 0 arrives.
//  - frame_No counts only error-free closing beats with s_ch == NUM_CH-1.
//  Undefined: s_ch is captured only. No realignment; groups are purely beat-counted. seq_err tied 0.
// STRUCTURE
//  - Package mua_pkg: NUM_CH, LANES, DW, CW constants; typedef mua_sample_t [DW-1:0], mua_ch_t [CW-1:0].
//  - Sub-module mua_ch_seq_check (expected_ch counter, compare, resync/drop flag, seq_err), instantiated
//    only under MUA_CH_CHECK_EN. The packer/output register stays in the top.
// TESTING
//  1 Channels 0..4, data 0x100+ch, back-to-back, m_comb_ready=1 -> one cycle after ch4:
//    m_comb_valid=1, m_comb_data={0x104..0x100}, m_comb_ch={4,3,2,1,0}.
//  2 Full frame ch 0..159 continuous, ready=1 -> 32 comb words, s_ready never low, frame_No 0->1
//    after the ch159 beat.
//  3 m_comb_ready=0 for 10 cycles during the 2nd group -> s_ready drops only at the ch9 beat,
//    word 1 held stable; after ready=1 both words are delivered in order with no loss or duplication.
//  4 Assert reset after ch0..2 accepted, then send ch0..4 -> only one word {4..0}; frame_No=0,
//    m_comb_valid=0 during reset.
//  5 (MUA_CH_CHECK_EN) ch 0,1,2,7,8,10..14 -> seq_err pulse at ch7, ch7/8 dropped, next word = ch 10..14;
//    no word containing 0..2.
//  6 frame_No preloaded near wrap (force 0xFFFFFFFF), complete a frame -> frame_No=0.

Source files
------------

// File: rtl/mua_pkg.sv
// Shared constants and sample/channel types for the MUA serial-to-parallel packer.
package mua_pkg;
  localparam int NUM_CH = 160;
  localparam int LANES  = 5;
  localparam int DW     = 32;
  localparam int CW     = 12;
  localparam int LANE_W = $clog2(LANES);

  typedef logic [DW-1:0] mua_sample_t;
  typedef logic [CW-1:0] mua_ch_t;
endpackage

// File: rtl/mua_ch_seq_check.sv
// Channel-sequence tracker: flags out-of-order beats and resynchronises on the next
// lane-0 channel, suppressing further error pulses while it waits.
module mua_ch_seq_check
  import mua_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_accept,
  input  mua_ch_t i_ch,
  output logic    o_beat_ok,
  output logic    o_restart,
  output logic    o_seq_err
);
  mua_ch_t r_expected_ch;
  logic    r_dropping;
  logic    r_seq_err;
  logic    w_match;
  logic    w_lane0;

  assign w_match   = !r_dropping && (i_ch == r_expected_ch);
  assign w_lane0   = (i_ch % CW'(LANES)) == '0;
  assign o_beat_ok = w_match;
  assign o_restart = !w_match && w_lane0;
  assign o_seq_err = r_seq_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_expected_ch <= '0;
      r_dropping    <= 1'b0;
      r_seq_err     <= 1'b0;
    end else begin
      // Only the first bad beat of a run reports; later drops are silent.
      r_seq_err <= i_accept && !w_match && !r_dropping;
      if (i_accept) begin
        if (w_match) begin
          r_expected_ch <= (r_expected_ch == CW'(NUM_CH - 1)) ? '0 : r_expected_ch + CW'(1);
        end else begin
          r_expected_ch <= i_ch + CW'(1);
          r_dropping    <= !w_lane0;
        end
      end
    end
  end
endmodule

// File: rtl/mua_serial_to_parallel.sv
// Packs serial (sample, channel) beats into LANES-wide comb words and counts frames.
// Optional channel-sequence checking/resync is enabled by defining MUA_CH_CHECK_EN.
module mua_serial_to_parallel
  import mua_pkg::*;
(
  input  logic                bus_clk,
  input  logic                xike_reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  mua_sample_t         s_data,
  input  mua_ch_t             s_ch,
  output logic                m_comb_valid,
  input  logic                m_comb_ready,
  output logic [LANES*DW-1:0] m_comb_data,
  output logic [LANES*CW-1:0] m_comb_ch,
  output logic [31:0]         frame_No,
  output logic                seq_err
);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANE_W-1:0]   r_lane_cnt;
  mua_sample_t         r_acc_data [LANES-1];
  mua_ch_t             r_acc_ch   [LANES-1];
  logic [LANES*DW-1:0] r_out_data;
  logic [LANES*CW-1:0] r_out_ch;
  logic                r_out_valid;
  logic [31:0]         r_frame_no;

  logic                w_accept;
  logic                w_last_lane;
  logic                w_closing;
  logic                w_acc_load;
  logic                w_beat_ok;
  logic                w_restart;
  logic                w_seq_err;
  logic [LANE_W-1:0]   w_lane;
  logic [LANES-2:0]    w_acc_we;
  logic [LANES*DW-1:0] w_word_data;
  logic [LANES*CW-1:0] w_word_ch;

`ifdef MUA_CH_CHECK_EN
  mua_ch_seq_check u_seq_check (
    .i_clk     (bus_clk),
    .i_rst_n   (xike_reset_n),
    .i_accept  (w_accept),
    .i_ch      (s_ch),
    .o_beat_ok (w_beat_ok),
    .o_restart (w_restart),
    .o_seq_err (w_seq_err)
  );
`else
  assign w_beat_ok = 1'b1;
  assign w_restart = 1'b0;
  assign w_seq_err = 1'b0;
`endif

  // Only the group-closing beat needs a free output register.
  assign w_last_lane = (r_lane_cnt == LAST_LANE);
  assign s_ready     = !w_last_lane || !r_out_valid || m_comb_ready;
  assign w_accept    = s_valid && s_ready;
  assign w_closing   = w_accept && w_beat_ok && w_last_lane;
  assign w_lane      = w_restart ? '0 : r_lane_cnt;
  assign w_acc_load  = w_accept && (w_restart || (w_beat_ok && !w_last_lane));

  genvar gi;
  generate
    for (gi = 0; gi < LANES - 1; gi++) begin : g_acc_lane
      assign w_acc_we[gi]               = w_acc_load && (w_lane == LANE_W'(gi));
      assign w_word_data[gi*DW +: DW]   = r_acc_data[gi];
      assign w_word_ch[gi*CW +: CW]     = r_acc_ch[gi];
    end
  endgenerate
  assign w_word_data[(LANES-1)*DW +: DW] = s_data;
  assign w_word_ch[(LANES-1)*CW +: CW]   = s_ch;

  always_ff @(posedge bus_clk) begin
    if (!xike_reset_n) begin
      r_lane_cnt <= '0;
      for (int k = 0; k < LANES - 1; k++) begin
        r_acc_data[k] <= '0;
        r_acc_ch[k]   <= '0;
      end
    end else begin
      if (w_accept) begin
        if (w_closing)      r_lane_cnt <= '0;
        else if (w_beat_ok) r_lane_cnt <= r_lane_cnt + LANE_W'(1);
        else if (w_restart) r_lane_cnt <= LANE_W'(1);
        else                r_lane_cnt <= '0;
      end
      for (int k = 0; k < LANES - 1; k++) begin
        if (w_acc_we[k]) begin
          r_acc_data[k] <= s_data;
          r_acc_ch[k]   <= s_ch;
        end
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!xike_reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_frame_no  <= '0;
    end else begin
      if (w_closing) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word_data;
        r_out_ch    <= w_word_ch;
      end else if (m_comb_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_closing && (s_ch == CW'(NUM_CH - 1))) begin
        r_frame_no <= r_frame_no + 32'd1;
      end
    end
  end

  assign m_comb_valid = r_out_valid;
  assign m_comb_data  = r_out_data;
  assign m_comb_ch    = r_out_ch;
  assign frame_No     = r_frame_no;
  assign seq_err      = w_seq_err;
endmodule

// File: tb/tb_mua_serial_to_parallel.sv
// Directed bench for mua_serial_to_parallel with a beat-queue scoreboard checked every cycle.
module tb_mua_serial_to_parallel;
  import mua_pkg::*;

  logic                bus_clk = 1'b0;
  logic                xike_reset_n = 1'b0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  mua_sample_t         s_data = '0;
  mua_ch_t             s_ch = '0;
  logic                m_comb_valid;
  logic                m_comb_ready = 1'b1;
  logic [LANES*DW-1:0] m_comb_data;
  logic [LANES*CW-1:0] m_comb_ch;
  logic [31:0]         frame_No;
  logic                seq_err;

  always #5 bus_clk = ~bus_clk;

  mua_serial_to_parallel dut (
    .bus_clk      (bus_clk),
    .xike_reset_n (xike_reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_ch         (s_ch),
    .m_comb_valid (m_comb_valid),
    .m_comb_ready (m_comb_ready),
    .m_comb_data  (m_comb_data),
    .m_comb_ch    (m_comb_ch),
    .frame_No     (frame_No),
    .seq_err      (seq_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int ch; logic [31:0] d; } beat_t;
  beat_t               grp[$];
  logic [LANES*DW-1:0] exp_data_q[$];
  logic [LANES*CW-1:0] exp_ch_q[$];
  logic [31:0]         m_frames = 0;
  bit                  m_synced = 1;
  int                  m_exp_ch = 0;
  bit                  m_exp_err = 0;
  bit                  preload_req = 0;
  int                  hs_cnt = 0;
  int                  seq_cnt = 0;
  int                  stall_chs[$];

  task automatic model_beat(input int ch, input logic [31:0] d);
    beat_t b;
    logic [LANES*DW-1:0] wd;
    logic [LANES*CW-1:0] wc;
    b.ch = ch;
    b.d  = d;
`ifdef MUA_CH_CHECK_EN
    if (m_synced && ch == m_exp_ch) begin
      grp.push_back(b);
      m_exp_ch = (ch == NUM_CH - 1) ? 0 : ch + 1;
    end else begin
      if (m_synced) m_exp_err = 1;
      grp.delete();
      if (ch % LANES == 0) begin
        m_synced = 1;
        grp.push_back(b);
        m_exp_ch = ch + 1;
      end else begin
        m_synced = 0;
      end
    end
`else
    grp.push_back(b);
`endif
    if (grp.size() == LANES) begin
      for (int k = 0; k < LANES; k++) begin
        wd[k*DW +: DW] = grp[k].d;
        wc[k*CW +: CW] = CW'(grp[k].ch);
      end
      exp_data_q.push_back(wd);
      exp_ch_q.push_back(wc);
      if (grp[LANES-1].ch == NUM_CH - 1) m_frames = m_frames + 32'd1;
      grp.delete();
    end
  endtask

  initial begin : model_and_compare
    bit          snap_rst, snap_acc, snap_hs, snap_pre;
    int          snap_ch;
    logic [31:0] snap_d;
    forever begin
      @(negedge bus_clk);
      #4;
      snap_rst = !xike_reset_n;
      snap_acc = s_valid && s_ready;
      snap_hs  = m_comb_valid && m_comb_ready;
      snap_ch  = int'(s_ch);
      snap_d   = s_data;
      snap_pre = preload_req;
      if (s_valid && !s_ready && xike_reset_n) stall_chs.push_back(int'(s_ch));
      @(posedge bus_clk);
      #1;
      m_exp_err = 0;
      if (snap_rst) begin
        grp.delete();
        exp_data_q.delete();
        exp_ch_q.delete();
        m_frames = 0;
        m_synced = 1;
        m_exp_ch = 0;
      end else begin
        if (snap_hs && exp_data_q.size() != 0) begin
          void'(exp_data_q.pop_front());
          void'(exp_ch_q.pop_front());
          hs_cnt++;
        end
        if (snap_acc) model_beat(snap_ch, snap_d);
        if (snap_pre) begin
          m_frames    = 32'hFFFF_FFFF;
          preload_req = 0;
        end
      end
      check("valid", m_comb_valid, exp_data_q.size() != 0);
      if (m_comb_valid && exp_data_q.size() != 0) begin
        check("word_data", m_comb_data, exp_data_q[0]);
        check("word_ch", m_comb_ch, exp_ch_q[0]);
      end
      check("frame_No", frame_No, m_frames);
      check("seq_err", seq_err, m_exp_err);
      if (seq_err) seq_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_beat(input int ch);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_ch    = CW'(ch);
    s_data  = 32'h100 + 32'(ch);
    #4;
    while (!s_ready) begin
      if (n >= 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: ch %0d never accepted, want accepted within 100 cycles", ch);
        break;
      end
      @(negedge bus_clk);
      #4;
      n++;
    end
    @(negedge bus_clk);
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int a, input int b);
    for (int c = a; c <= b; c++) send_beat(c);
  endtask

  task automatic do_reset();
    @(negedge bus_clk);
    xike_reset_n = 1'b0;
    repeat (2) @(negedge bus_clk);
    xike_reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int hs0;
    int bad_stall;
    do_reset();
    check("reset_valid", m_comb_valid, 1'b0);
    check("reset_frame_No", frame_No, 32'd0);
    check("reset_data", m_comb_data, '0);

    // T1: one group, 1-cycle latency
    send_range(0, 4);
    $display("T1 word: valid=%0b data=%0h ch=%0h", m_comb_valid, m_comb_data, m_comb_ch);
    check("t1_valid", m_comb_valid, 1'b1);
    check("t1_data", m_comb_data, {32'h104, 32'h103, 32'h102, 32'h101, 32'h100});
    check("t1_ch", m_comb_ch, {12'd4, 12'd3, 12'd2, 12'd1, 12'd0});

    // T2: full frame, no stalls
    do_reset();
    stall_chs.delete();
    hs0 = hs_cnt;
    send_range(0, NUM_CH - 1);
    repeat (3) @(negedge bus_clk);
    $display("T2 frame: words=%0d stalls=%0d frame_No=%0d", hs_cnt - hs0, stall_chs.size(), frame_No);
    check("t2_words", hs_cnt - hs0, 32);
    check("t2_stalls", stall_chs.size(), 0);
    check("t2_frame_No", frame_No, 32'd1);

    // T3: backpressure during the second group
    do_reset();
    hs0 = hs_cnt;
    send_range(0, 4);
    m_comb_ready = 1'b0;
    stall_chs.delete();
    fork
      send_range(5, 9);
      begin
        repeat (10) @(negedge bus_clk);
        m_comb_ready = 1'b1;
      end
    join
    repeat (3) @(negedge bus_clk);
    bad_stall = 0;
    foreach (stall_chs[i]) if (stall_chs[i] != 9) bad_stall++;
    $display("T3 backpressure: stalls=%0d off_ch9=%0d words=%0d", stall_chs.size(), bad_stall, hs_cnt - hs0);
    check("t3_stall_count", stall_chs.size(), 6);
    check("t3_stall_only_ch9", bad_stall, 0);
    check("t3_words", hs_cnt - hs0, 2);

    // T4: reset discards a partial group
    do_reset();
    send_range(0, 2);
    @(negedge bus_clk);
    xike_reset_n = 1'b0;
    @(negedge bus_clk);
    check("t4_valid_in_reset", m_comb_valid, 1'b0);
    @(negedge bus_clk);
    xike_reset_n = 1'b1;
    hs0 = hs_cnt;
    send_range(0, 4);
    check("t4_data", m_comb_data, {32'h104, 32'h103, 32'h102, 32'h101, 32'h100});
    check("t4_ch", m_comb_ch, {12'd4, 12'd3, 12'd2, 12'd1, 12'd0});
    repeat (3) @(negedge bus_clk);
    $display("T4 reset: words=%0d frame_No=%0d", hs_cnt - hs0, frame_No);
    check("t4_words", hs_cnt - hs0, 1);
    check("t4_frame_No", frame_No, 32'd0);

`ifdef MUA_CH_CHECK_EN
    // T5: sequence error and resync at ch10
    do_reset();
    hs0 = hs_cnt;
    seq_cnt = 0;
    send_range(0, 2);
    send_beat(7);
    send_beat(8);
    send_range(10, 14);
    check("t5_data", m_comb_data, {32'h10e, 32'h10d, 32'h10c, 32'h10b, 32'h10a});
    check("t5_ch", m_comb_ch, {12'd14, 12'd13, 12'd12, 12'd11, 12'd10});
    repeat (3) @(negedge bus_clk);
    $display("T5 seq: seq_err pulses=%0d words=%0d", seq_cnt, hs_cnt - hs0);
    check("t5_seq_pulses", seq_cnt, 1);
    check("t5_words", hs_cnt - hs0, 1);
`endif

    // T6: frame counter wrap
    do_reset();
    @(negedge bus_clk);
    force dut.r_frame_no = 32'hFFFF_FFFF;
    preload_req = 1;
    @(negedge bus_clk);
    release dut.r_frame_no;
    @(negedge bus_clk);
    check("t6_preload", frame_No, 32'hFFFF_FFFF);
    send_range(155, 159);
    @(negedge bus_clk);
    $display("T6 wrap: frame_No=%0h", frame_No);
    check("t6_wrap", frame_No, 32'd0);

    repeat (3) @(negedge bus_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
